// File: rtl/dsp_multiplier.sv
// dsp_multiplier: pipelined unsigned WIDTH x WIDTH multiplier with a fixed LATENCY,
// with registers placed to fit a DSP slice (operand regs, M reg, P reg, extra delay regs).
module dsp_multiplier #(
  parameter int WIDTH   = 18,
  parameter int LATENCY = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [2*WIDTH-1:0]   result
);
  localparam int PW = 2 * WIDTH;
  if (WIDTH < 1 || WIDTH > 64 || LATENCY < 1 || LATENCY > 8) begin : g_bad
    $error("dsp_multiplier: WIDTH must be 1..64 and LATENCY 1..8");
  end
  if (LATENCY == 1) begin : g_l1
    logic [PW-1:0] p;
    always_ff @(posedge clock or negedge reset)
      if (!reset) p <= '0;
      else p <= PW'(A) * PW'(B);
    assign result = p;
  end else begin : g_ln
    logic [WIDTH-1:0] a_q, b_q;
    // pipe[0] is the M stage; every later entry is the P stage or an extra delay stage
    logic [PW-1:0] pipe [LATENCY-1];
    always_ff @(posedge clock or negedge reset)
      if (!reset) begin
        a_q <= '0;
        b_q <= '0;
        for (int i = 0; i < LATENCY - 1; i++) pipe[i] <= '0;
      end else begin
        a_q <= A;
        b_q <= B;
        pipe[0] <= PW'(a_q) * PW'(b_q);
        for (int i = 1; i < LATENCY - 1; i++) pipe[i] <= pipe[i-1];
      end
    assign result = pipe[LATENCY-2];
  end
endmodule

// File: tb/tb_dsp_multiplier.sv
// tb_dsp_multiplier: random and directed checks of several dsp_multiplier configurations
// against a history-based product model that honours latency and reset flushing.
module tb_dsp_multiplier;
  logic        clock = 0;
  logic        reset = 1;
  logic [63:0] a_r = 0, b_r = 0;
  logic [35:0] r18;
  logic [15:0] r8_1, r8_2, r8_4, r8_8;
  logic [1:0]  r1;
  logic [73:0] r37;
  int checks = 0, errors = 0;
  int k = 0, flush = 0;
  logic [63:0] ha [0:1023];
  logic [63:0] hb [0:1023];
  bit          hv [0:1023];

  always #5 clock = ~clock;

  dsp_multiplier #(.WIDTH(18), .LATENCY(3)) u18  (.clock(clock), .reset(reset), .A(a_r[17:0]), .B(b_r[17:0]), .result(r18));
  dsp_multiplier #(.WIDTH(8),  .LATENCY(1)) u8_1 (.clock(clock), .reset(reset), .A(a_r[7:0]),  .B(b_r[7:0]),  .result(r8_1));
  dsp_multiplier #(.WIDTH(8),  .LATENCY(2)) u8_2 (.clock(clock), .reset(reset), .A(a_r[7:0]),  .B(b_r[7:0]),  .result(r8_2));
  dsp_multiplier #(.WIDTH(8),  .LATENCY(4)) u8_4 (.clock(clock), .reset(reset), .A(a_r[7:0]),  .B(b_r[7:0]),  .result(r8_4));
  dsp_multiplier #(.WIDTH(8),  .LATENCY(8)) u8_8 (.clock(clock), .reset(reset), .A(a_r[7:0]),  .B(b_r[7:0]),  .result(r8_8));
  dsp_multiplier #(.WIDTH(1),  .LATENCY(3)) u1   (.clock(clock), .reset(reset), .A(a_r[0:0]),  .B(b_r[0:0]),  .result(r1));
  dsp_multiplier #(.WIDTH(37), .LATENCY(3)) u37  (.clock(clock), .reset(reset), .A(a_r[36:0]), .B(b_r[36:0]), .result(r37));

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Edge k captured operands ha[k]/hb[k]; a capture is valid if reset was high and no reset came after it.
  function automatic logic [127:0] exp_of(int w, int l);
    int j = k - l + 1;
    logic [127:0] m, x, y;
    if (j < 1 || j <= flush || !hv[j]) return '0;
    m = (128'(1) << w) - 1;
    x = 128'(ha[j]) & m;
    y = 128'(hb[j]) & m;
    return x * y;
  endfunction

  always @(posedge clock) begin
    k++;
    if (k < 1024) begin
      ha[k] = a_r;
      hb[k] = b_r;
      hv[k] = reset;
    end
  end

  always @(negedge reset) flush = k;

  always @(negedge clock) if (k > 0 && k < 1024) begin
    check("w18l3", 128'(r18),  exp_of(18, 3));
    check("w8l1",  128'(r8_1), exp_of(8, 1));
    check("w8l2",  128'(r8_2), exp_of(8, 2));
    check("w8l4",  128'(r8_4), exp_of(8, 4));
    check("w8l8",  128'(r8_8), exp_of(8, 8));
    check("w1l3",  128'(r1),   exp_of(1, 3));
    check("w37l3", 128'(r37),  exp_of(37, 3));
  end

  task automatic zeros_now(input string tag);
    check({tag, "_r18"}, 128'(r18), '0);
    check({tag, "_r8_8"}, 128'(r8_8), '0);
    check({tag, "_r37"}, 128'(r37), '0);
  endtask

  initial begin
    int c1, c2, c4, c8;
    logic [63:0] ones = '1;
    #1 reset = 0;
    #1 zeros_now("por_reset");
    a_r = 5; b_r = 7;
    repeat (4) @(negedge clock);
    zeros_now("held_reset");
    reset = 1;
    repeat (3) @(negedge clock);
    check("first35", 128'(r18), 128'd35);
    for (int i = 0; i < 5; i++) begin
      a_r = 64'(i); b_r = 64'(i + 1);
      @(negedge clock);
    end
    a_r = ones; b_r = ones;
    @(negedge clock); a_r = ones; b_r = 0;
    @(negedge clock); a_r = 1;    b_r = ones;
    @(negedge clock); a_r = 0;    b_r = 0;
    check("max18", 128'(r18), 128'h0_FFFF_8000_1);
    check("max37", 128'(r37), (128'(1) << 74) - (128'(1) << 38) + 1);
    check("max1",  128'(r1),  128'd1);
    @(negedge clock);
    check("maxx0", 128'(r18), '0);
    @(negedge clock);
    check("onexmax", 128'(r18), 128'h3FFFF);
    for (int i = 0; i < 6; i++) begin
      a_r = 64'(i + 10); b_r = 64'(i + 11);
      @(negedge clock);
    end
    #2 reset = 0;
    #1 zeros_now("mid_reset");
    @(negedge clock);
    zeros_now("mid_held");
    reset = 1;
    for (int i = 0; i < 10; i++) begin
      a_r = 64'(i + 30); b_r = 64'(i + 31);
      @(negedge clock);
    end
    a_r = 0; b_r = 0;
    repeat (9) @(negedge clock);
    a_r = 200; b_r = 3;
    @(negedge clock);
    a_r = 0; b_r = 0;
    c1 = 0; c2 = 0; c4 = 0; c8 = 0;
    for (int i = 0; i < 12; i++) begin
      c1 += int'(r8_1 == 16'd600);
      c2 += int'(r8_2 == 16'd600);
      c4 += int'(r8_4 == 16'd600);
      c8 += int'(r8_8 == 16'd600);
      @(negedge clock);
    end
    check("pulse_l1", 128'(c1), 128'd1);
    check("pulse_l2", 128'(c2), 128'd1);
    check("pulse_l4", 128'(c4), 128'd1);
    check("pulse_l8", 128'(c8), 128'd1);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0: begin a_r = ones; b_r = ones; end
        1: begin a_r = 0; b_r = {$urandom, $urandom}; end
        default: begin a_r = {$urandom, $urandom}; b_r = {$urandom, $urandom}; end
      endcase
      if (i == 150) begin
        #2 reset = 0;
        #1 zeros_now("rand_reset");
        @(negedge clock);
        reset = 1;
      end else @(negedge clock);
    end
    a_r = 0; b_r = 0;
    repeat (10) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsp_multiplier.md
Name: dsp_multiplier

Overview:
Fully pipelined unsigned WIDTH x WIDTH multiplier with a configurable, fixed latency. Its register placement maps onto a vendor DSP slice: input registers, a multiplier register and an output register. It is the building block for multiplier arrays and arithmetic datapaths. It accepts a new operand pair every clock and returns the full 2*WIDTH-bit product exactly LATENCY clocks later.

Parameters:
WIDTH, 18, operand width in bits for A and B; legal range 1..64.
LATENCY, 3, clock edges from operand capture to product on result; legal range 1..8. Any other value is an elaboration-time error.

Ports:
clock  input  1  rising-edge clock for all registers.
reset  input  1  asynchronous, active-low reset; clears every pipeline register.
A  input  WIDTH  unsigned multiplicand.
B  input  WIDTH  unsigned multiplier.
result  output  2*WIDTH  unsigned product A*B, registered.

Behaviour:
- Arithmetic is unsigned with a full-precision 2*WIDTH-bit product. There is no truncation, rounding, saturation or overflow.
- Throughput is one product per clock; no enable, valid or handshake. Every edge captures A and B.
- Operands sampled at rising edge N appear on result immediately after edge N+LATENCY-1 (counting the capture edge as the first). The product is stable through edge N+LATENCY.
- Register placement by LATENCY:
  - LATENCY=1: product computed combinationally and registered once into result.
  - LATENCY=2: A and B registered, then the product is registered into result.
  - LATENCY=3: A and B registered, then the product registered (M stage), then copied to the result register (P stage).
  - LATENCY>3: as LATENCY=3, plus LATENCY-3 extra 2*WIDTH-bit delay registers after the P stage.
- result is always driven from a register, never combinationally from the inputs.
- Reset (reset=0):
  - Asynchronously clears all operand, product and delay registers to 0. result becomes 0 without waiting for a clock edge.
  - While reset is held low, result stays 0 regardless of A, B or clock.
- Reset release (reset 0->1):
  - The first edge with reset=1 captures A/B.
  - result stays 0 until that capture emerges LATENCY cycles later; stale data never appears.
- Reset mid-stream flushes all in-flight products; nothing captured before the reset assertion ever reaches result.
- Power-up/initial register value is 0, the same as the reset value.
- Boundary cases:
  - A or B equal to 0 gives 0.
  - A=B=2^WIDTH-1 gives 2^(2*WIDTH)-2^(WIDTH+1)+1. All 2*WIDTH bits must be correct.
- Any WIDTH in range must simulate identically with a single behavioural product. Synthesis may split wide operands across multiple DSP slices, but latency must remain exactly LATENCY.

Test Plan:
- WIDTH=18, LATENCY=3; hold reset low 4 clocks with A=5, B=7 -> result=0 throughout and at release. result=35 appears exactly 3 edges after the first edge with reset=1.
- Back-to-back stream after reset: (A,B)=(0,1),(1,2),(2,3),(3,4),(4,5) on consecutive edges -> result=0,2,6,12,20 on consecutive cycles, starting 3 edges after the first capture. No bubbles or repeats.
- Extremes: A=B=0x3FFFF -> result=0xFFFF80001. A=0x3FFFF, B=0 -> 0. A=1, B=0x3FFFF -> 0x3FFFF.
- Reset mid-stream: streaming (n, n+1), assert reset asynchronously between edges -> result goes to 0 before the next edge. After release, only products of post-release operands appear, at the correct latency.
- Latency sweep: LATENCY in {1,2,4,8} with WIDTH=8; single pulse A=200, B=3 for one cycle then zeros -> result=600 for exactly one cycle, LATENCY edges after capture; 0 otherwise.
- Narrow and wide widths: WIDTH=1 with A=B=1 -> 1. WIDTH=37 with A=B=2^37-1 -> 2^74-2^38+1 after LATENCY.
